req_pend_sched: RTL and testbench

//  Collects single-cycle request pulses from 16 sources into a sticky pending vector.

---
 rtl/req_pend_sched_if.sv | 28 ++
 rtl/req_pend_sched.sv | 95 +++++++++
 tb/tb_req_pend_sched.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/req_pend_sched_if.sv
// Handshake/status bundle between the request sources, the pending-vector
// scheduler and the downstream index consumer.
interface req_pend_sched_if #(
    parameter int NSRC  = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 5
);
    logic [NSRC-1:0]  req_vld;
    logic             flush;
    logic             out_vld;
    logic             out_rdy;
    logic [IDX_W-1:0] out_idx;
    logic [CNT_W-1:0] pend_cnt;
    logic             busy;
    logic             dup_err;

    // Scheduler side
    modport slave (
        input  req_vld, flush, out_rdy,
        output out_vld, out_idx, pend_cnt, busy, dup_err
    );

    // Sources / consumer side
    modport master (
        output req_vld, flush, out_rdy,
        input  out_vld, out_idx, pend_cnt, busy, dup_err
    );
endinterface

// File: rtl/req_pend_sched.sv
// Sticky pending-request collector with fixed-priority (lowest index first)
// issue through a registered valid/ready stage. Tracks duplicate requests
// and supports a synchronous flush of all pending and staged work.
module req_pend_sched #(
    parameter int NSRC  = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    req_pend_sched_if.slave  bus
);
    logic [NSRC-1:0]  pend_q, pend_d;
    logic             out_vld_q, out_vld_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic             dup_err_q, dup_err_d;

    logic             ld;
    logic             any_pend;
    logic [IDX_W-1:0] sel_idx;
    logic [NSRC-1:0]  clr_mask;

    // Lowest set bit of the registered pending vector; scan high-to-low so
    // the last (lowest) hit wins.
    always_comb begin
        sel_idx  = '0;
        any_pend = |pend_q;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_q[i]) sel_idx = IDX_W'(i);
        end
    end

    // Output stage load, pending update (set beats clear), dup detection, flush
    always_comb begin
        ld        = !out_vld_q || bus.out_rdy;
        clr_mask  = '0;
        pend_d    = pend_q;
        out_vld_d = out_vld_q;
        out_idx_d = out_idx_q;
        dup_err_d = dup_err_q;

        if (ld) begin
            out_vld_d = any_pend;
            if (any_pend) begin
                out_idx_d         = sel_idx;
                clr_mask[sel_idx] = 1'b1;
            end
        end

        // A request landing on the entry being issued this cycle is a fresh
        // request, not a duplicate.
        if (|(bus.req_vld & pend_q & ~clr_mask)) dup_err_d = 1'b1;

        pend_d = (pend_q & ~clr_mask) | bus.req_vld;

        // Flush wins over everything; out_idx keeps its last value.
        if (bus.flush) begin
            pend_d    = '0;
            out_vld_d = 1'b0;
            dup_err_d = 1'b0;
        end
    end

    // Population count of the next pending vector, registered alongside it
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < NSRC; i++) begin
            pend_cnt_d = pend_cnt_d + CNT_W'(pend_d[i]);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            out_vld_q  <= 1'b0;
            out_idx_q  <= '0;
            pend_cnt_q <= '0;
            dup_err_q  <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            out_vld_q  <= out_vld_d;
            out_idx_q  <= out_idx_d;
            pend_cnt_q <= pend_cnt_d;
            dup_err_q  <= dup_err_d;
        end
    end

    assign bus.out_vld  = out_vld_q;
    assign bus.out_idx  = out_idx_q;
    assign bus.pend_cnt = pend_cnt_q;
    assign bus.dup_err  = dup_err_q;
    assign bus.busy     = any_pend || out_vld_q;
endmodule

// File: tb/tb_req_pend_sched.sv
// Directed bench for req_pend_sched: hand-computed expectations checked
// with immediate assertions one step at a time.
module tb_req_pend_sched;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    req_pend_sched_if bus ();

    req_pend_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int vld, input int idx, input int cnt);
        chk({tag, ".vld"}, int'(bus.out_vld), vld);
        if (vld != 0) chk({tag, ".idx"}, int'(bus.out_idx), idx);
        chk({tag, ".cnt"}, int'(bus.pend_cnt), cnt);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.req_vld = '0;
        bus.flush   = 1'b0;
        bus.out_rdy = 1'b1;

        // Reset state
        #2;
        chk("rst.vld", int'(bus.out_vld), 0);
        chk("rst.idx", int'(bus.out_idx), 0);
        chk("rst.cnt", int'(bus.pend_cnt), 0);
        chk("rst.dup", int'(bus.dup_err), 0);
        chk("rst.busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 8101: issues 0, 8, 15 back to back
        bus.req_vld = 16'h8101;
        tick();
        bus.req_vld = '0;
        chk_out("t2.c1", 0, 0, 3);
        chk("t2.busy", int'(bus.busy), 1);
        tick(); chk_out("t2.c2", 1, 0, 2);
        tick(); chk_out("t2.c3", 1, 8, 1);
        tick(); chk_out("t2.c4", 1, 15, 0);
        tick(); chk_out("t2.c5", 0, 0, 0);
        chk("t2.busy0", int'(bus.busy), 0);

        // 0100 alone encodes as 8
        bus.req_vld = 16'h0100;
        tick();
        bus.req_vld = '0;
        chk_out("t3.c1", 0, 0, 1);
        tick(); chk_out("t3.c2", 1, 8, 0);
        tick(); chk_out("t3.c3", 0, 0, 0);

        // Stall holds idx 1; request 0 during stall wins once released
        bus.out_rdy = 1'b0;
        bus.req_vld = 16'h0006;
        tick();
        bus.req_vld = '0;
        chk_out("t4.c1", 0, 0, 2);
        tick(); chk_out("t4.c2", 1, 1, 1);
        bus.req_vld = 16'h0001;
        tick();
        bus.req_vld = '0;
        chk_out("t4.c3", 1, 1, 2);
        tick(); chk_out("t4.c4", 1, 1, 2);
        bus.out_rdy = 1'b1;
        tick(); chk_out("t4.c5", 1, 0, 1);
        tick(); chk_out("t4.c6", 1, 2, 0);
        tick(); chk_out("t4.c7", 0, 0, 0);
        chk("t4.dup", int'(bus.dup_err), 0);

        // Duplicate on pending 3 during stall sets sticky dup_err
        bus.out_rdy = 1'b0;
        bus.req_vld = 16'h0009;
        tick();
        bus.req_vld = '0;
        tick(); chk_out("t5.c2", 1, 0, 1);
        chk("t5.dup0", int'(bus.dup_err), 0);
        bus.req_vld = 16'h0008;
        tick();
        bus.req_vld = '0;
        chk("t5.dup1", int'(bus.dup_err), 1);
        chk_out("t5.c3", 1, 0, 1);
        tick(); chk("t5.dup_sticky", int'(bus.dup_err), 1);
        bus.req_vld = 16'h0008;
        tick();
        bus.req_vld = '0;
        chk("t5.dup2", int'(bus.dup_err), 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t5.fl.dup", int'(bus.dup_err), 0);
        chk_out("t5.fl", 0, 0, 0);
        chk("t5.fl.busy", int'(bus.busy), 0);

        // Request coinciding with issue of 3 is not a dup and re-pends 3
        bus.out_rdy = 1'b1;
        bus.req_vld = 16'h0008;
        tick();
        chk_out("t5b.c1", 0, 0, 1);
        tick();
        bus.req_vld = '0;
        chk_out("t5b.c2", 1, 3, 1);
        chk("t5b.dup_a", int'(bus.dup_err), 0);
        tick(); chk_out("t5b.c3", 1, 3, 0);
        chk("t5b.dup_b", int'(bus.dup_err), 0);
        tick(); chk_out("t5b.c4", 0, 0, 0);

        // Flush with full pend, staged entry, dup set and a request in flight
        bus.out_rdy = 1'b0;
        bus.req_vld = 16'hFFFF;
        tick();
        bus.req_vld = '0;
        chk_out("t6.c1", 0, 0, 16);
        tick(); chk_out("t6.c2", 1, 0, 15);
        bus.req_vld = 16'h0003;
        tick();
        bus.req_vld = '0;
        chk_out("t6.c3", 1, 0, 16);
        chk("t6.dup", int'(bus.dup_err), 1);
        bus.flush   = 1'b1;
        bus.req_vld = 16'h0001;
        bus.out_rdy = 1'b1;
        tick();
        bus.flush   = 1'b0;
        bus.req_vld = '0;
        chk_out("t6.fl", 0, 0, 0);
        chk("t6.fl.dup", int'(bus.dup_err), 0);
        chk("t6.fl.busy", int'(bus.busy), 0);
        tick(); chk_out("t6.after", 0, 0, 0);
        chk("t6.after.busy", int'(bus.busy), 0);

        // Asynchronous reset in the middle of a stall
        bus.out_rdy = 1'b0;
        bus.req_vld = 16'h0006;
        tick();
        bus.req_vld = '0;
        tick(); chk_out("t1.c2", 1, 1, 1);
        bus.req_vld = 16'h0004;
        tick();
        bus.req_vld = '0;
        chk("t1.dup", int'(bus.dup_err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1.rst.vld", int'(bus.out_vld), 0);
        chk("t1.rst.idx", int'(bus.out_idx), 0);
        chk("t1.rst.cnt", int'(bus.pend_cnt), 0);
        chk("t1.rst.dup", int'(bus.dup_err), 0);
        chk("t1.rst.busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.out_rdy = 1'b1;
        tick();
        tick();
        chk("t1.rel.vld", int'(bus.out_vld), 0);
        chk("t1.rel.busy", int'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
